pipe_stage_skid: RTL and testbench

//   Parametrised inter-stage pipeline register (IF/ID, ID/EXE, EXE/MEM, MEM/WB) with valid/ready flow control.
//   Two entries: output register plus skid register, so in_ready depends only on the block's own state.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipe_data_reg.sv | 21 ++
 rtl/pipe_stage_skid.sv | 115 +++++++++++
 tb/tb_pipe_stage_skid.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage registers: FSM encoding, occupancy width
// and the per-stage payload layouts packed into in_data by each stage.
package pipe_pkg;

    localparam int unsigned PIPE_OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic        branch;
        logic [63:0] alu_result;
        logic [63:0] rt_data;
        logic [4:0]  dest_reg;
    } exe_mem_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [63:0] mem_data;
        logic [63:0] alu_result;
        logic [4:0]  dest_reg;
    } mem_wb_t;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with synchronous clear (to RESET_VAL) taking priority over load.
module pipe_data_reg #(
    parameter int unsigned       DATA_W    = 64,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry (main + skid) pipeline stage register with valid/ready, stall and flush.
// Optional build macro PIPE_ZERO_ON_BUBBLE_EN forces out_data to RESET_VAL while empty.
//
//   state | meaning
//   EMPTY | no entry held, out_valid low
//   ONE   | main register holds the entry presented downstream
//   FULL  | main presented, skid holds the next entry; in_ready low
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W    = 64,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [PIPE_OCC_W-1:0] occupancy
);

    pipe_state_t       state, state_nxt;
    logic              acc, dep;
    logic              clr;
    logic              main_load, main_from_skid, skid_load;
    logic [DATA_W-1:0] main_d, main_q, skid_q;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign acc       = in_valid & in_ready;
    assign dep       = out_valid & out_ready;
    assign clr       = rst | flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        occupancy      = PIPE_OCC_W'(0);
        case (state)
            EMPTY: begin
                if (acc) begin
                    main_load = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                occupancy = PIPE_OCC_W'(1);
                if (acc && dep) begin
                    main_load = 1'b1;
                end else if (acc) begin
                    skid_load = 1'b1;
                    state_nxt = FULL;
                end else if (dep) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                occupancy = PIPE_OCC_W'(2);
                if (dep) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    pipe_data_reg #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk  (clk),
        .clr  (clr),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    pipe_data_reg #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk  (clk),
        .clr  (clr),
        .load (skid_load),
        .d    (in_data),
        .q    (skid_q)
    );

`ifdef PIPE_ZERO_ON_BUBBLE_EN
    // Keep stale control bits from leaking out of an empty stage.
    assign out_data = out_valid ? main_q : RESET_VAL;
`else
    assign out_data = main_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed reset/stream/stall/flush cases then random traffic.
module tb_pipe_stage_skid;

    localparam int unsigned DW = 32;
    localparam logic [DW-1:0] RV = 32'h5A5A_0000;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W    (DW),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    logic [DW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven: score the
    // handshake the next rising edge will see, then check state after it.
    task automatic step();
        logic [DW-1:0] front;
        if (out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
                check("out_valid_unexpected", {31'b0, out_valid}, '0);
            end else begin
                front = exp_q.pop_front();
                check("out_data", out_data, front);
            end
        end
        if (rst || flush) begin
            exp_q.delete();
        end else if (in_valid && in_ready === 1'b1) begin
            exp_q.push_back(in_data);
        end
        @(posedge clk);
        @(negedge clk);
        check("occupancy", {30'b0, occupancy}, DW'(exp_q.size()));
        check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
        check("in_ready",  {31'b0, in_ready},  {31'b0, exp_q.size() < 2});
    endtask

    task automatic drain();
        int cyc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            step();
            cyc++;
        end
        check("drain_left", DW'(exp_q.size()), '0);
    endtask

    task automatic send(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h99;
        out_ready = 1'b1;
        @(negedge clk);

        // reset with in_valid high
        step();
        step();
        check("rst_out_data", out_data, RV);
        rst = 1'b0;

        // back-to-back streaming
        for (int i = 1; i <= 8; i++) send(DW'(i));
        drain();

        // stall with skid fill
        send(32'hA);
        out_ready = 1'b0;
        send(32'hB);
        send(32'hC);
        check("stall_in_ready", {31'b0, in_ready}, '0);
        check("stall_out_data", out_data, 32'hA);
        step();
        out_ready = 1'b1;
        step();
        step();
        drain();

        // flush while FULL, nothing accepted
        out_ready = 1'b0;
        send(32'h11);
        send(32'h22);
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b1;
        send(32'h55);
        check("after_flush_data", out_data, 32'h55);
        drain();

        // flush with simultaneous accept in ONE
        out_ready = 1'b0;
        send(32'h33);
        out_ready = 1'b1;
        flush     = 1'b1;
        send(32'h77);
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush_drop_77", {31'b0, out_data == 32'h77}, '0);
        end

        // bubble output value
        send(32'hDEAD);
        in_valid = 1'b0;
        step();
`ifdef PIPE_ZERO_ON_BUBBLE_EN
        check("bubble_data", out_data, RV);
`else
        check("bubble_data", out_data, 32'hDEAD);
`endif

        // random traffic with occasional flush
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
